// File: rtl/wb_mem_arbiter_if.sv
// Wishbone bundle between the two memory masters, the arbiter and the
// unified memory; slave is the arbiter's view, master the environment's.
interface wb_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i;
  logic          m0_we_i;
  logic          m0_cyc_i;
  logic          m0_stb_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o;
  logic          m0_err_o;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic          m1_we_i;
  logic          m1_cyc_i;
  logic          m1_stb_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o;
  logic          m1_err_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_we_o;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  modport slave (
    input  m0_adr_i, m0_dat_i, m0_we_i,
    input  m0_cyc_i, m0_stb_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_adr_i, m1_dat_i, m1_we_i,
    input  m1_cyc_i, m1_stb_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_we_o,
    output s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i,
    output grant_o, timeout_o
  );

  modport master (
    output m0_adr_i, m0_dat_i, m0_we_i,
    output m0_cyc_i, m0_stb_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_adr_i, m1_dat_i, m1_we_i,
    output m1_cyc_i, m1_stb_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_we_o,
    input  s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Round-robin, non-preemptive two-master Wishbone arbiter with a
// stall watchdog that errors the owner when the memory never acks.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  wb_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [15:0]   cnt, cnt_nx;
  logic          gnt0, gnt1;
  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;
  logic          stall, hit;

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    unique case (1'b1)
      gnt0: begin
        own_cyc = bus.m0_cyc_i;
        own_stb = bus.m0_stb_i;
        own_we  = bus.m0_we_i;
        own_adr = bus.m0_adr_i;
        own_dat = bus.m0_dat_i;
      end
      gnt1: begin
        own_cyc = bus.m1_cyc_i;
        own_stb = bus.m1_stb_i;
        own_we  = bus.m1_we_i;
        own_adr = bus.m1_adr_i;
        own_dat = bus.m1_dat_i;
      end
      default: ;
    endcase
  end

  // an ack in the timeout cycle wins, so hit needs a stalled strobe
  assign stall = own_stb & ~bus.s_ack_i;
  assign hit   = stall & (cnt == TO_LAST);
  assign cnt_nx = (stall & ~hit) ? cnt + 16'd1 : 16'd0;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (bus.m0_cyc_i & bus.m1_cyc_i)
          state_nx = last ? OWN0 : OWN1;
        else if (bus.m0_cyc_i)
          state_nx = OWN0;
        else if (bus.m1_cyc_i)
          state_nx = OWN1;
      end
      OWN0: if (!bus.m0_cyc_i) state_nx = IDLE;
      OWN1: if (!bus.m1_cyc_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state_nx == OWN0)
      last_nx = 1'b0;
    else if (state_nx == OWN1)
      last_nx = 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 16'd0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  assign bus.s_adr_o   = own_adr;
  assign bus.s_dat_o   = own_dat;
  assign bus.s_we_o    = own_we;
  assign bus.s_cyc_o   = own_cyc;
  assign bus.s_stb_o   = own_stb & ~hit;
  assign bus.grant_o   = {gnt1, gnt0};
  assign bus.timeout_o = hit;

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m0_ack_o = bus.s_ack_i & gnt0 & bus.m0_stb_i;
  assign bus.m1_ack_o = bus.s_ack_i & gnt1 & bus.m1_stb_i;
  assign bus.m0_err_o = hit & gnt0;
  assign bus.m1_err_o = hit & gnt1;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed and random stimulus for wb_mem_arbiter, checked against a
// cycle-level ownership/watchdog model.
module tb_wb_mem_arbiter;
  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  int   m_owner;
  int   m_last;
  int   m_cnt;
  logic m_hit;

  wb_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  wb_mem_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(TO)
  ) dut (
    .wb_clk  (clk),
    .wb_rst_n(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    m_hit   = 1'b0;
  endtask

  task automatic zero_inputs();
    bus.m0_adr_i = '0; bus.m0_dat_i = '0;
    bus.m0_we_i  = 0;  bus.m0_cyc_i = 0;
    bus.m0_stb_i = 0;
    bus.m1_adr_i = '0; bus.m1_dat_i = '0;
    bus.m1_we_i  = 0;  bus.m1_cyc_i = 0;
    bus.m1_stb_i = 0;
    bus.s_dat_i  = '0; bus.s_ack_i  = 0;
  endtask

  // mid-cycle: compare every output against the model
  task automatic mid();
    logic        ocyc, ostb, owe;
    logic [31:0] oadr, odat;
    logic [1:0]  g;
    @(negedge clk);
    ocyc = 0; ostb = 0; owe = 0;
    oadr = 0; odat = 0; g = 2'b00;
    if (m_owner == 0) begin
      ocyc = bus.m0_cyc_i; ostb = bus.m0_stb_i;
      owe  = bus.m0_we_i;  oadr = bus.m0_adr_i;
      odat = bus.m0_dat_i; g = 2'b01;
    end else if (m_owner == 1) begin
      ocyc = bus.m1_cyc_i; ostb = bus.m1_stb_i;
      owe  = bus.m1_we_i;  oadr = bus.m1_adr_i;
      odat = bus.m1_dat_i; g = 2'b10;
    end
    m_hit = ostb && !bus.s_ack_i && (m_cnt + 1 == TO);
    chk("s_cyc", bus.s_cyc_o, ocyc);
    chk("s_stb", bus.s_stb_o, ostb && !m_hit);
    chk("s_we", bus.s_we_o, owe);
    chk("s_adr", bus.s_adr_o, oadr);
    chk("s_dat", bus.s_dat_o, odat);
    chk("grant", bus.grant_o, g);
    chk("m0_ack", bus.m0_ack_o,
        bus.s_ack_i && m_owner == 0 && bus.m0_stb_i);
    chk("m1_ack", bus.m1_ack_o,
        bus.s_ack_i && m_owner == 1 && bus.m1_stb_i);
    chk("m0_err", bus.m0_err_o, m_hit && m_owner == 0);
    chk("m1_err", bus.m1_err_o, m_hit && m_owner == 1);
    chk("timeout", bus.timeout_o, m_hit);
    chk("m0_dat", bus.m0_dat_o, bus.s_dat_i);
    chk("m1_dat", bus.m1_dat_o, bus.s_dat_i);
  endtask

  // clock edge: advance ownership and stall count
  task automatic adv();
    logic c0, c1, oc, os;
    @(posedge clk);
    c0 = bus.m0_cyc_i;
    c1 = bus.m1_cyc_i;
    if (m_owner < 0) begin
      m_cnt = 0;
      if (c0 && c1) m_owner = (m_last == 1) ? 0 : 1;
      else if (c0)  m_owner = 0;
      else if (c1)  m_owner = 1;
      if (m_owner >= 0) m_last = m_owner;
    end else begin
      oc = (m_owner == 0) ? c0 : c1;
      os = (m_owner == 0) ? bus.m0_stb_i : bus.m1_stb_i;
      if (!oc) begin
        m_owner = -1;
        m_cnt = 0;
      end else if (bus.s_ack_i || !os || m_hit)
        m_cnt = 0;
      else
        m_cnt++;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      mid();
      adv();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    #2;
    chk("rst_grant", bus.grant_o, 2'b00);
    chk("rst_cyc", bus.s_cyc_o, 1'b0);
    chk("rst_adr", bus.s_adr_o, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // tie from reset goes to m0, then alternation
    bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
    run(1);
    mid(); chk("t2_g01", bus.grant_o, 2'b01); adv();
    bus.m0_cyc_i = 0;
    run(1);
    mid(); chk("t2_gap", bus.grant_o, 2'b00);
    chk("t2_gap_cyc", bus.s_cyc_o, 1'b0); adv();
    mid(); chk("t2_g10", bus.grant_o, 2'b10); adv();
    bus.m1_cyc_i = 0;
    run(1);
    bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
    mid(); chk("t2_idle", bus.grant_o, 2'b00); adv();
    mid(); chk("t2_g01b", bus.grant_o, 2'b01); adv();
    bus.m0_cyc_i = 0; bus.m1_cyc_i = 0;
    run(2);

    // m0 holds the bus over 3 transfers
    bus.m0_cyc_i = 1;
    run(1);
    bus.m1_cyc_i = 1; bus.m0_stb_i = 1;
    for (int i = 0; i < 6; i++) begin
      bus.s_ack_i = (i % 2 == 1);
      bus.s_dat_i = $urandom;
      mid(); chk("t3_hold", bus.grant_o, 2'b01); adv();
    end
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    bus.s_ack_i = 0;
    mid(); chk("t3_e1", bus.grant_o, 2'b01); adv();
    mid(); chk("t3_e2", bus.grant_o, 2'b00); adv();
    mid(); chk("t3_m1", bus.grant_o, 2'b10); adv();
    bus.m1_cyc_i = 0;
    run(2);

    // simple m0 read, then a late ack after cyc drops
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    bus.m0_adr_i = 32'h100;
    run(1);
    mid();
    chk("t1_cyc", bus.s_cyc_o, 1'b1);
    chk("t1_adr", bus.s_adr_o, 32'h100);
    adv();
    bus.s_ack_i = 1; bus.s_dat_i = 32'hDEADBEEF;
    mid();
    chk("t1_ack", bus.m0_ack_o, 1'b1);
    chk("t1_dat", bus.m0_dat_o, 32'hDEADBEEF);
    chk("t1_nack1", bus.m1_ack_o, 1'b0);
    adv();
    bus.s_ack_i = 0; bus.m0_cyc_i = 0;
    run(1);
    bus.s_ack_i = 1;
    mid();
    chk("t6_ack0", bus.m0_ack_o, 1'b0);
    chk("t6_ack1", bus.m1_ack_o, 1'b0);
    adv();
    zero_inputs();
    run(2);

    // watchdog on m1, then ack wins in the timeout cycle
    bus.m1_cyc_i = 1;
    run(1);
    bus.m1_stb_i = 1;
    for (int i = 1; i <= TO; i++) begin
      mid();
      chk("t4_err", bus.m1_err_o, i == TO);
      chk("t4_to", bus.timeout_o, i == TO);
      chk("t4_stb", bus.s_stb_o, i != TO);
      adv();
    end
    for (int i = 1; i <= TO; i++) begin
      bus.s_ack_i = (i == TO);
      mid();
      chk("t4_ackw", bus.m1_ack_o, i == TO);
      chk("t4_noerr", bus.m1_err_o, 1'b0);
      adv();
    end
    mid(); chk("t4_keep", bus.grant_o, 2'b10); adv();
    zero_inputs();
    run(2);

    // async reset mid-transfer
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    run(1);
    bus.s_ack_i = 1;
    mid();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cyc", bus.s_cyc_o, 1'b0);
    chk("t5_stb", bus.s_stb_o, 1'b0);
    chk("t5_ack", bus.m0_ack_o, 1'b0);
    chk("t5_grant", bus.grant_o, 2'b00);
    model_reset();
    bus.s_ack_i = 0; bus.m0_stb_i = 0;
    bus.m1_cyc_i = 1;
    #1 rst_n = 1'b1;
    adv();
    mid(); chk("t5_tie", bus.grant_o, 2'b01); adv();
    zero_inputs();
    run(2);

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      if (!bus.m0_cyc_i)
        bus.m0_cyc_i = ($urandom_range(0, 3) == 0);
      else
        bus.m0_cyc_i = ($urandom_range(0, 9) != 0);
      if (!bus.m1_cyc_i)
        bus.m1_cyc_i = ($urandom_range(0, 3) == 0);
      else
        bus.m1_cyc_i = ($urandom_range(0, 9) != 0);
      bus.m0_stb_i = bus.m0_cyc_i &&
                     ($urandom_range(0, 2) != 0);
      bus.m1_stb_i = bus.m1_cyc_i &&
                     ($urandom_range(0, 2) != 0);
      bus.m0_we_i  = $urandom_range(0, 1);
      bus.m1_we_i  = $urandom_range(0, 1);
      bus.m0_adr_i = $urandom;
      bus.m1_adr_i = $urandom;
      bus.m0_dat_i = $urandom;
      bus.m1_dat_i = $urandom;
      bus.s_dat_i  = $urandom;
      bus.s_ack_i  = ($urandom_range(0, 3) == 0);
      mid();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
